// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Main-decoder FSM for the multi-cycle RV32I core; sequences
//                fetch/decode/execute/memory/writeback and counts retirements.
//  Revision    : 1.0
// ============================================================================
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int BRANCH_EXT = 0,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            func3,
    input  logic                  func7_5,
    input  logic                  ZeroFlag,
    input  logic                  LtFlag,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [ALU_CTRL_W-1:0] ALUcontrol,
    output logic [2:0]            ImmSrc,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired
);

    localparam logic [ALU_CTRL_W-1:0] c_ALU_ADD = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_SUB = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_AND = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_OR  = ALU_CTRL_W'(3'b011);
    localparam logic [ALU_CTRL_W-1:0] c_ALU_SLT = ALU_CTRL_W'(3'b101);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR_WB  = 4'd12,
        S_LUI_WB   = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_illegal;
    logic [CNT_W-1:0]        r_retired;
    logic                    w_br_legal;
    logic                    w_br_taken;
    logic [ALU_CTRL_W-1:0]   w_alu_op;
    logic                    w_pcwrite;
    logic                    w_irwrite;
    logic                    w_memwrite;
    logic                    w_regwrite;

    // Unsigned-compare branches (bltu/bgeu) are not supported and trap.
    always_comb begin
        w_br_legal = (func3 == 3'b000) ||
                     ((BRANCH_EXT != 0) && (func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b101));
        case (func3)
            3'b000:  w_br_taken = ZeroFlag;
            3'b001:  w_br_taken = ~ZeroFlag;
            3'b100:  w_br_taken = LtFlag;
            3'b101:  w_br_taken = ~LtFlag;
            default: w_br_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:  w_alu_op = (r_state == S_EXEC_R && func7_5) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_alu_op = c_ALU_SLT;
            3'b110:  w_alu_op = c_ALU_OR;
            3'b111:  w_alu_op = c_ALU_AND;
            default: w_alu_op = c_ALU_ADD;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    7'b0000011,
                    7'b0100011: w_next = S_MEMADR;
                    7'b0110011: w_next = S_EXEC_R;
                    7'b0010011: w_next = S_EXEC_I;
                    7'b1100011: w_next = S_BRANCH;
                    7'b1101111: w_next = S_JAL;
                    7'b1100111: w_next = S_JALR;
                    7'b0110111: w_next = S_LUI_WB;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC_R,
            S_EXEC_I,
            S_JAL:      w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = w_br_legal ? S_FETCH : S_TRAP;
            S_JALR:     w_next = S_JALR_WB;
            S_JALR_WB,
            S_LUI_WB:   w_next = S_FETCH;
            default:    w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_TRAP)
                r_illegal <= 1'b1;
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUcontrol = c_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUcontrol = w_alu_op;
            end
            S_EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUcontrol = w_alu_op;
            end
            S_ALUWB:    w_regwrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUcontrol = func3[2] ? c_ALU_SLT : c_ALU_SUB;
                w_pcwrite  = w_br_legal & w_br_taken;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_JALR_WB: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_regwrite = 1'b1;
            end
            S_LUI_WB: begin
                ResultSrc  = 2'b11;
                w_regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 3'b001;
            7'b1100011: ImmSrc = 3'b010;
            7'b0110111: ImmSrc = 3'b011;
            7'b1101111: ImmSrc = 3'b100;
            default:    ImmSrc = 3'b000;
        endcase
    end

    // Write enables are held off for the whole reset cycle, whatever the state.
    assign PCWrite  = w_pcwrite  & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign illegal  = r_illegal;
    assign retired  = r_retired;

endmodule
`default_nettype wire
